// File: rtl/score_bcd_accumulator.sv
// Digit-serial BCD score accumulator: buffers point pulses, adds a fixed BCD
// increment one digit per cycle, saturates at all nines and tracks a high score.

module score_bcd_accumulator_chk #(
   parameter int DIGITS = 4
) (
   input logic                  CLK,
   input logic                  RST,
   input logic [4*DIGITS-1:0]   SCORE,
   input logic [4*DIGITS-1:0]   HIGH,
   input logic                  BUSY,
   input logic                  UPD
);

   function automatic logic bcd_ok(input logic [4*DIGITS-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (v[d*4 +: 4] > 4'd9) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

   // Structural invariants of the committed outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         assert (bcd_ok(SCORE));
         assert (bcd_ok(HIGH));
         assert (HIGH >= SCORE);
         assert (!(UPD && BUSY));
      end
   end

endmodule

module score_bcd_accumulator #(
   parameter int                  DIGITS     = 4,
   parameter logic [4*DIGITS-1:0] POINTS_BCD = 16'h0010,
   parameter int                  PEND_W     = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  P,
   input  logic                  CLR,
   output logic [4*DIGITS-1:0]   SCORE,
   output logic [4*DIGITS-1:0]   HIGH,
   output logic                  BUSY,
   output logic                  UPD,
   output logic                  SAT,
   output logic                  DROP
);

   localparam int                W         = 4 * DIGITS;
   localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [W-1:0]      ALL_NINES = {DIGITS{4'h9}};
   localparam logic [W-1:0]      ZERO_W    = {W{1'b0}};
   localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
   localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1'b1);
   localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1'b1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_CMP  = 2'd2
   } state_t;

   // Returns {carry_out, digit} for one decimal digit position
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                input logic [3:0] b,
                                                input logic       cin);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      if (s > 5'd9) begin
         return {1'b1, 4'(s - 5'd10)};
      end else begin
         return {1'b0, s[3:0]};
      end
   endfunction

   state_t              state_r, state_s;
   logic [W-1:0]        work_r, score_r, high_r, commit_s;
   logic [IDX_W-1:0]    idx_r;
   logic                carry_r;
   logic [PEND_W-1:0]   pend_r, pend_s;
   logic                sat_r, upd_r, drop_r, busy_r;
   logic                launch_s, last_s, pend_full_s, accept_s, drop_s;
   logic                overflow_s, raise_s;
   logic [4:0]          sum_s;

   // Next-state logic of the add sequencer
   always_comb begin
      state_s  = state_r;
      launch_s = 1'b0;
      last_s   = (idx_r == IDX_LAST);
      case (state_r)
         ST_IDLE: begin
            if (pend_r != PEND_ZERO) begin
               state_s  = ST_ADD;
               launch_s = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ADD: begin
            if (last_s) begin
               state_s = ST_CMP;
            end else begin
               state_s = ST_ADD;
            end
         end
         ST_CMP:  state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Pending-pulse bookkeeping; a full queue discards the pulse unless a launch frees a slot
   always_comb begin
      pend_s      = pend_r;
      pend_full_s = (pend_r == PEND_MAX);
      drop_s      = P && pend_full_s && !launch_s;
      accept_s    = P && !drop_s;
      case ({accept_s, launch_s})
         2'b10:   pend_s = pend_r + PEND_ONE;
         2'b01:   pend_s = pend_r - PEND_ONE;
         default: pend_s = pend_r;
      endcase
   end

   // Digit adder and commit value
   always_comb begin
      sum_s      = bcd_digit_add(work_r[{idx_r, 2'b00} +: 4],
                                 POINTS_BCD[{idx_r, 2'b00} +: 4], carry_r);
      overflow_s = carry_r || sat_r;
      if (overflow_s) begin
         commit_s = ALL_NINES;
      end else begin
         commit_s = work_r;
      end
      raise_s = (commit_s > high_r);
   end

   // Register update; reset dominates clear, clear aborts any add in flight
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_r <= ST_IDLE;
         work_r  <= ZERO_W;
         idx_r   <= IDX_ZERO;
         carry_r <= 1'b0;
         pend_r  <= PEND_ZERO;
         score_r <= ZERO_W;
         high_r  <= ZERO_W;
         sat_r   <= 1'b0;
         upd_r   <= 1'b0;
         drop_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else if (CLR) begin
         state_r <= ST_IDLE;
         work_r  <= ZERO_W;
         idx_r   <= IDX_ZERO;
         carry_r <= 1'b0;
         pend_r  <= PEND_ZERO;
         score_r <= ZERO_W;
         sat_r   <= 1'b0;
         upd_r   <= 1'b0;
         drop_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         pend_r  <= pend_s;
         upd_r   <= (state_r == ST_CMP);
         drop_r  <= drop_s;
         busy_r  <= (state_s != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (launch_s) begin
                  work_r  <= score_r;
                  idx_r   <= IDX_ZERO;
                  carry_r <= 1'b0;
               end
            end
            ST_ADD: begin
               work_r[{idx_r, 2'b00} +: 4] <= sum_s[3:0];
               carry_r                     <= sum_s[4];
               if (!last_s) begin
                  idx_r <= idx_r + IDX_ONE;
               end
            end
            ST_CMP: begin
               score_r <= commit_s;
               if (overflow_s) begin
                  sat_r <= 1'b1;
               end
               if (raise_s) begin
                  high_r <= commit_s;
               end
            end
            default: begin
               work_r <= work_r;
            end
         endcase
      end
   end

   assign SCORE = score_r;
   assign HIGH  = high_r;
   assign BUSY  = busy_r;
   assign UPD   = upd_r;
   assign SAT   = sat_r;
   assign DROP  = drop_r;

   score_bcd_accumulator_chk #(.DIGITS(DIGITS)) u_chk (
      .CLK   (CLK),
      .RST   (RST),
      .SCORE (score_r),
      .HIGH  (high_r),
      .BUSY  (busy_r),
      .UPD   (upd_r)
   );

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Directed bench for score_bcd_accumulator: a +10 instance and a +5000
// instance used for saturation.

module tb_score_bcd_accumulator;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, p, clr;
   logic [15:0] score, high;
   logic        busy, upd, sat, drop;

   logic        rst2, p2, clr2;
   logic [15:0] score2, high2;
   logic        busy2, upd2, sat2, drop2;

   int errors = 0;
   int checks = 0;

   score_bcd_accumulator #(.DIGITS(4), .POINTS_BCD(16'h0010), .PEND_W(2)) u_dut (
      .CLK(clk), .RST(rst), .P(p), .CLR(clr),
      .SCORE(score), .HIGH(high), .BUSY(busy), .UPD(upd), .SAT(sat), .DROP(drop)
   );

   score_bcd_accumulator #(.DIGITS(4), .POINTS_BCD(16'h5000), .PEND_W(2)) u_sat (
      .CLK(clk), .RST(rst2), .P(p2), .CLR(clr2),
      .SCORE(score2), .HIGH(high2), .BUSY(busy2), .UPD(upd2), .SAT(sat2), .DROP(drop2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_points(input int n);
      for (int i = 0; i < n; i++) begin
         p = 1'b1;
         tick();
         p = 1'b0;
         repeat (6) tick();
      end
   endtask

   task automatic add_points_sat(input int n);
      for (int i = 0; i < n; i++) begin
         p2 = 1'b1;
         tick();
         p2 = 1'b0;
         repeat (6) tick();
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; rst2 = 1'b0;
      tick();
      tick();
      checks++;
      if ({score, high} !== 32'h0000_0000) begin
         errors++; $display("FAIL reset_score_high: got %h/%h expected 0000/0000", score, high);
      end
      checks++;
      if ({busy, upd, sat, drop} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, upd, sat, drop});
      end
      checks++;
      if ({score2, sat2, busy2} !== 18'h0) begin
         errors++; $display("FAIL reset_sat_inst: got %h sat=%b busy=%b expected 0000/0/0", score2, sat2, busy2);
      end
      rst = 1'b1; rst2 = 1'b1;
   endtask

   task automatic test_single();
      p = 1'b1;
      tick();
      p = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL single_busy_k: got %b expected 0", busy);
      end
      for (int j = 1; j <= 5; j++) begin
         tick();
         checks++;
         if ({busy, upd, score} !== {1'b1, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL single_in_flight k+%0d: got busy=%b upd=%b score=%h expected 1/0/0000", j, busy, upd, score);
         end
      end
      tick();
      checks++;
      if (score !== 16'h0010) begin
         errors++; $display("FAIL single_score: got %h expected 0010", score);
      end
      checks++;
      if (high !== 16'h0010) begin
         errors++; $display("FAIL single_high: got %h expected 0010", high);
      end
      checks++;
      if ({upd, busy} !== 2'b10) begin
         errors++; $display("FAIL single_upd_busy: got upd=%b busy=%b expected 1/0", upd, busy);
      end
      tick();
      checks++;
      if (upd !== 1'b0) begin
         errors++; $display("FAIL single_upd_width: got %b expected 0", upd);
      end
   endtask

   task automatic test_carry();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (score !== 16'h0000) begin
         errors++; $display("FAIL carry_clr: got %h expected 0000", score);
      end
      add_points(9);
      checks++;
      if (score !== 16'h0090) begin
         errors++; $display("FAIL carry_90: got %h expected 0090", score);
      end
      add_points(1);
      checks++;
      if (score !== 16'h0100) begin
         errors++; $display("FAIL carry_100: got %h expected 0100", score);
      end
      add_points(90);
      checks++;
      if (score !== 16'h1000) begin
         errors++; $display("FAIL carry_1000: got %h expected 1000", score);
      end
      checks++;
      if (high !== 16'h1000) begin
         errors++; $display("FAIL carry_high: got %h expected 1000", high);
      end
   endtask

   task automatic test_burst_drop();
      int drop_cnt = 0;
      int drop_at  = -1;
      int upd_cnt  = 0;
      int upd_times[8];
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int c = 0; c < 30; c++) begin
         p = (c < 5);
         tick();
         if (drop === 1'b1) begin
            drop_cnt++;
            drop_at = c;
         end
         if (upd === 1'b1 && upd_cnt < 8) begin
            upd_times[upd_cnt] = c;
            upd_cnt++;
         end
      end
      p = 1'b0;
      checks++;
      if (drop_cnt != 1 || drop_at != 4) begin
         errors++; $display("FAIL burst_drop: got count=%0d at=%0d expected count=1 at=4", drop_cnt, drop_at);
      end
      checks++;
      if (upd_cnt != 4) begin
         errors++; $display("FAIL burst_upd_count: got %0d expected 4", upd_cnt);
      end
      for (int u = 0; u < 4 && u < upd_cnt; u++) begin
         checks++;
         if (upd_times[u] != 6 * (u + 1)) begin
            errors++; $display("FAIL burst_upd_time[%0d]: got k+%0d expected k+%0d", u, upd_times[u], 6 * (u + 1));
         end
      end
      checks++;
      if (score !== 16'h0040) begin
         errors++; $display("FAIL burst_score: got %h expected 0040", score);
      end
   endtask

   task automatic test_clr_mid_add();
      logic seen_upd;
      logic seen_busy;
      pulse_reset();
      add_points(3);
      checks++;
      if ({score, high} !== 32'h0030_0030) begin
         errors++; $display("FAIL clr_preload: got %h/%h expected 0030/0030", score, high);
      end
      p = 1'b1;
      tick();
      tick();
      tick();
      p = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL clr_busy_before: got %b expected 1", busy);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if ({score, busy, upd} !== {16'h0000, 1'b0, 1'b0}) begin
         errors++; $display("FAIL clr_after: got score=%h busy=%b upd=%b expected 0000/0/0", score, busy, upd);
      end
      checks++;
      if (high !== 16'h0030) begin
         errors++; $display("FAIL clr_high_kept: got %h expected 0030", high);
      end
      seen_upd = 1'b0;
      seen_busy = 1'b0;
      // P in the same cycle as CLR must be ignored as well
      p = 1'b1;
      clr = 1'b1;
      tick();
      p = 1'b0;
      clr = 1'b0;
      for (int j = 0; j < 12; j++) begin
         tick();
         seen_upd  = seen_upd | upd;
         seen_busy = seen_busy | busy;
      end
      checks++;
      if ({seen_upd, seen_busy, score} !== {1'b0, 1'b0, 16'h0000}) begin
         errors++; $display("FAIL clr_quiet: got upd=%b busy=%b score=%h expected 0/0/0000", seen_upd, seen_busy, score);
      end
      add_points(1);
      repeat (8) tick();
      checks++;
      if (score !== 16'h0010) begin
         errors++; $display("FAIL clr_pend_empty: got %h expected 0010", score);
      end
   endtask

   task automatic test_high_score();
      pulse_reset();
      add_points(5);
      checks++;
      if ({score, high} !== 32'h0050_0050) begin
         errors++; $display("FAIL high_50: got %h/%h expected 0050/0050", score, high);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      add_points(3);
      checks++;
      if ({score, high} !== 32'h0030_0050) begin
         errors++; $display("FAIL high_30: got %h/%h expected 0030/0050", score, high);
      end
      add_points(3);
      checks++;
      if ({score, high} !== 32'h0060_0060) begin
         errors++; $display("FAIL high_60: got %h/%h expected 0060/0060", score, high);
      end
      pulse_reset();
      checks++;
      if ({score, high} !== 32'h0000_0000) begin
         errors++; $display("FAIL high_rst: got %h/%h expected 0000/0000", score, high);
      end
   endtask

   task automatic test_saturation();
      add_points_sat(1);
      checks++;
      if ({score2, sat2} !== {16'h5000, 1'b0}) begin
         errors++; $display("FAIL sat_first: got %h sat=%b expected 5000/0", score2, sat2);
      end
      add_points_sat(1);
      checks++;
      if ({score2, sat2, upd2} !== {16'h9999, 1'b1, 1'b1}) begin
         errors++; $display("FAIL sat_second: got %h sat=%b upd=%b expected 9999/1/1", score2, sat2, upd2);
      end
      checks++;
      if (high2 !== 16'h9999) begin
         errors++; $display("FAIL sat_high: got %h expected 9999", high2);
      end
      add_points_sat(1);
      checks++;
      if ({score2, sat2, upd2, busy2, drop2} !== {16'h9999, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         errors++; $display("FAIL sat_third: got %h sat=%b upd=%b busy=%b drop=%b expected 9999/1/1/0/0",
                            score2, sat2, upd2, busy2, drop2);
      end
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;
      checks++;
      if ({score2, sat2, high2} !== {16'h0000, 1'b0, 16'h9999}) begin
         errors++; $display("FAIL sat_clr: got %h sat=%b high=%h expected 0000/0/9999", score2, sat2, high2);
      end
   endtask

   initial begin
      rst = 1'b0; p = 1'b0; clr = 1'b0;
      rst2 = 1'b0; p2 = 1'b0; clr2 = 1'b0;
      test_reset();
      test_single();
      test_carry();
      test_burst_drop();
      test_clr_mid_add();
      test_high_score();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
